// File: rtl/msdap_pkg.sv
// ---------------------------------------------------------------------------
// msdap_pkg
// Shared definitions for the MSDAP main sequencing controller:
//   - controller state encoding (the value driven on the State output)
//   - memory sizes, the zero-run length and the address widths derived from them
//   - address/counter typedefs and a small helper for zero-pair detection
// ---------------------------------------------------------------------------
package msdap_pkg;

    localparam int RJ_WORDS   = 16;
    localparam int COEF_WORDS = 512;
    localparam int DATA_DEPTH = 256;
    localparam int ZERO_RUN   = 800;

    localparam int RJ_AW   = $clog2(RJ_WORDS);
    localparam int COEF_AW = $clog2(COEF_WORDS);
    localparam int DATA_AW = $clog2(DATA_DEPTH);
    localparam int CLR_W   = DATA_AW + 1;
    localparam int ZC_W    = 10;

    typedef logic [RJ_AW-1:0]   rj_addr_t;
    typedef logic [COEF_AW-1:0] coef_addr_t;
    typedef logic [DATA_AW-1:0] data_addr_t;
    typedef logic [CLR_W-1:0]   clr_cnt_t;
    typedef logic [ZC_W-1:0]    zero_cnt_t;

    localparam rj_addr_t   RJ_LAST   = rj_addr_t'(RJ_WORDS - 1);
    localparam coef_addr_t COEF_LAST = coef_addr_t'(COEF_WORDS - 1);
    // The sweep counter carries one extra bit so that reaching DATA_DEPTH
    // marks "all addresses cleared" one cycle after the last clear write.
    localparam clr_cnt_t   CLR_END   = clr_cnt_t'(DATA_DEPTH);
    localparam zero_cnt_t  ZC_LAST   = zero_cnt_t'(ZERO_RUN - 1);
    localparam zero_cnt_t  ZC_MAX    = '1;

    // CLEARING shares code 0 with INIT; an internal flag tells them apart.
    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_WAIT_RJ   = 3'd1,
        ST_READ_RJ   = 3'd2,
        ST_WAIT_COEF = 3'd3,
        ST_READ_COEF = 3'd4,
        ST_WAIT_DATA = 3'd5,
        ST_WORKING   = 3'd6,
        ST_SLEEPING  = 3'd7
    } msdap_state_e;

    function automatic logic is_zero_pair(input logic [15:0] left, input logic [15:0] right);
        return (left == 16'd0) && (right == 16'd0);
    endfunction

endpackage

// File: rtl/msdap_zero_detect.sv
// ---------------------------------------------------------------------------
// msdap_zero_detect
// Counts consecutive all-zero sample pairs with a 10-bit saturating counter.
// Ports:
//   clk        in   system clock (Sclk)
//   reset      in   synchronous active-high reset
//   clear      in   forces the run count to zero
//   pair_valid in   a data pair is being accepted this cycle
//   pair_zero  in   the accepted pair is all-zero
//   run_last   out  the run is one pair short of ZERO_RUN, so a further zero
//                   pair brings the run to ZERO_RUN
// ---------------------------------------------------------------------------
module msdap_zero_detect
    import msdap_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic pair_valid,
    input  logic pair_zero,
    output logic run_last
);

    zero_cnt_t run_count;

    // Any nonzero pair breaks the run; zero pairs extend it, saturating at
    // the counter maximum so a long silence can never wrap back to a short run.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            run_count <= '0;
        end else if (pair_valid) begin
            if (!pair_zero) begin
                run_count <= '0;
            end else if (run_count != ZC_MAX) begin
                run_count <= run_count + 1'b1;
            end
        end
    end

    // Exported as "one short" rather than "reached" so the controller can
    // act on the very pair that completes the run without a feedback path.
    assign run_last = (run_count == ZC_LAST);

endmodule

// File: rtl/msdap_main_ctrl.sv
// ---------------------------------------------------------------------------
// msdap_main_ctrl
// Main sequencing controller for the MSDAP stereo FIR datapath (Sclk domain).
// Steers incoming L/R word pairs into Rj, coefficient and data memories,
// issues per-sample compute starts, and handles init sweep, flush and sleep.
// Ports:
//   Sclk          in   system clock
//   Reset         in   synchronous active-high block reset
//   Start         in   one-cycle pulse, same effect as Reset
//   Flush_req     in   level, high while the external reset is asserted
//   Word_valid    in   one-cycle strobe, WordL/WordR hold a new pair
//   WordL, WordR  in   left/right 16-bit words
//   State         out  current state code
//   InReady       out  datapath accepts serial input
//   Rj_we/addr    out  Rj memory write strobe and address
//   Coef_we/addr  out  coefficient memory write strobe and address
//   Data_we/clr   out  data memory write strobe; clr selects zero data
//   Data_addr     out  data memory write address (circular)
//   Compute_start out  one-cycle pulse, ALU computes the sample at Data_addr
//   Sleep         out  high while sleeping on a zero input run
// All outputs are registered; a pair accepted at one edge shows its strobes
// during the following cycle.
// ---------------------------------------------------------------------------
module msdap_main_ctrl
    import msdap_pkg::*;
(
    input  logic        Sclk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Flush_req,
    input  logic        Word_valid,
    input  logic [15:0] WordL,
    input  logic [15:0] WordR,
    output logic [2:0]  State,
    output logic        InReady,
    output logic        Rj_we,
    output logic [3:0]  Rj_addr,
    output logic        Coef_we,
    output logic [8:0]  Coef_addr,
    output logic        Data_we,
    output logic        Data_clr,
    output logic [7:0]  Data_addr,
    output logic        Compute_start,
    output logic        Sleep
);

    msdap_state_e state, state_next;
    logic         clearing, clearing_next;
    clr_cnt_t     clr_cnt, clr_cnt_next;
    rj_addr_t     rj_ptr, rj_ptr_next;
    coef_addr_t   coef_ptr, coef_ptr_next;
    data_addr_t   data_ptr, data_ptr_next;

    logic         rj_we_q, rj_we_next;
    rj_addr_t     rj_addr_q, rj_addr_next;
    logic         coef_we_q, coef_we_next;
    coef_addr_t   coef_addr_q, coef_addr_next;
    logic         data_we_q, data_we_next;
    logic         data_clr_q, data_clr_next;
    data_addr_t   data_addr_q, data_addr_next;
    logic         compute_q, compute_next;
    logic         in_ready_q, in_ready_next;
    logic         sleep_q, sleep_next;

    logic         block_reset;
    logic         pair_zero;
    logic         run_last;
    logic         zc_clear;
    logic         zc_valid;
    logic         data_accept;
    logic         start_clear;

    // Start is a soft re-initialisation and behaves exactly like Reset.
    assign block_reset = Reset | Start;
    assign pair_zero   = is_zero_pair(WordL, WordR);

    msdap_zero_detect u_zero_detect (
        .clk        (Sclk),
        .reset      (block_reset),
        .clear      (zc_clear),
        .pair_valid (zc_valid),
        .pair_zero  (pair_zero),
        .run_last   (run_last)
    );

    // Next-state and next-output logic. Strobes default low each cycle; the
    // sweep, load and data paths raise at most one of them.
    always_comb begin
        state_next     = state;
        clearing_next  = clearing;
        clr_cnt_next   = clr_cnt;
        rj_ptr_next    = rj_ptr;
        coef_ptr_next  = coef_ptr;
        data_ptr_next  = data_ptr;
        rj_we_next     = 1'b0;
        rj_addr_next   = rj_addr_q;
        coef_we_next   = 1'b0;
        coef_addr_next = coef_addr_q;
        data_we_next   = 1'b0;
        data_clr_next  = 1'b0;
        data_addr_next = data_addr_q;
        compute_next   = 1'b0;
        zc_clear       = 1'b0;
        zc_valid       = 1'b0;
        data_accept    = 1'b0;
        start_clear    = 1'b0;

        case (state)
            // Used for both power-up init and mid-stream clearing: one zero
            // write per cycle, then hand over depending on which sweep it was.
            ST_INIT: begin
                if (clr_cnt == CLR_END) begin
                    state_next     = clearing ? ST_WAIT_DATA : ST_WAIT_RJ;
                    clearing_next  = 1'b0;
                    clr_cnt_next   = '0;
                    data_ptr_next  = '0;
                    data_addr_next = '0;
                    zc_clear       = 1'b1;
                end else begin
                    data_we_next   = 1'b1;
                    data_clr_next  = 1'b1;
                    data_addr_next = clr_cnt[DATA_AW-1:0];
                    clr_cnt_next   = clr_cnt + 1'b1;
                end
            end
            ST_WAIT_RJ, ST_READ_RJ: begin
                if (Word_valid) begin
                    rj_we_next   = 1'b1;
                    rj_addr_next = rj_ptr;
                    if (rj_ptr == RJ_LAST) begin
                        rj_ptr_next = '0;
                        state_next  = ST_WAIT_COEF;
                    end else begin
                        rj_ptr_next = rj_ptr + 1'b1;
                        state_next  = ST_READ_RJ;
                    end
                end
            end
            ST_WAIT_COEF, ST_READ_COEF: begin
                if (Word_valid) begin
                    coef_we_next   = 1'b1;
                    coef_addr_next = coef_ptr;
                    if (coef_ptr == COEF_LAST) begin
                        coef_ptr_next = '0;
                        state_next    = ST_WAIT_DATA;
                    end else begin
                        coef_ptr_next = coef_ptr + 1'b1;
                        state_next    = ST_READ_COEF;
                    end
                end
            end
            // Held here while the external reset is still asserted after a flush.
            ST_WAIT_DATA: begin
                if (Word_valid && !Flush_req) begin
                    data_accept = 1'b1;
                end
            end
            ST_WORKING: begin
                if (Flush_req) begin
                    start_clear = 1'b1;
                end else if (Word_valid) begin
                    data_accept = 1'b1;
                end
            end
            // Zero pairs are dropped entirely; a nonzero pair wakes us up and
            // is processed in the same cycle.
            ST_SLEEPING: begin
                if (Flush_req) begin
                    start_clear = 1'b1;
                end else if (Word_valid && !pair_zero) begin
                    data_accept = 1'b1;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase

        // Flush has priority over any word arriving in the same cycle.
        if (start_clear) begin
            state_next    = ST_INIT;
            clearing_next = 1'b1;
            clr_cnt_next  = '0;
            zc_clear      = 1'b1;
        end

        // The pair that completes the zero run is still written and computed.
        if (data_accept) begin
            data_we_next   = 1'b1;
            compute_next   = 1'b1;
            data_addr_next = data_ptr;
            data_ptr_next  = data_ptr + 1'b1;
            zc_valid       = 1'b1;
            state_next     = (pair_zero && run_last) ? ST_SLEEPING : ST_WORKING;
        end

        in_ready_next = (state_next != ST_INIT);
        sleep_next    = (state_next == ST_SLEEPING);
    end

    // State and registered outputs.
    always_ff @(posedge Sclk) begin
        if (block_reset) begin
            state       <= ST_INIT;
            clearing    <= 1'b0;
            clr_cnt     <= '0;
            rj_ptr      <= '0;
            coef_ptr    <= '0;
            data_ptr    <= '0;
            rj_we_q     <= 1'b0;
            rj_addr_q   <= '0;
            coef_we_q   <= 1'b0;
            coef_addr_q <= '0;
            data_we_q   <= 1'b0;
            data_clr_q  <= 1'b0;
            data_addr_q <= '0;
            compute_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            sleep_q     <= 1'b0;
        end else begin
            state       <= state_next;
            clearing    <= clearing_next;
            clr_cnt     <= clr_cnt_next;
            rj_ptr      <= rj_ptr_next;
            coef_ptr    <= coef_ptr_next;
            data_ptr    <= data_ptr_next;
            rj_we_q     <= rj_we_next;
            rj_addr_q   <= rj_addr_next;
            coef_we_q   <= coef_we_next;
            coef_addr_q <= coef_addr_next;
            data_we_q   <= data_we_next;
            data_clr_q  <= data_clr_next;
            data_addr_q <= data_addr_next;
            compute_q   <= compute_next;
            in_ready_q  <= in_ready_next;
            sleep_q     <= sleep_next;
        end
    end

    assign State         = state;
    assign InReady       = in_ready_q;
    assign Rj_we         = rj_we_q;
    assign Rj_addr       = rj_addr_q;
    assign Coef_we       = coef_we_q;
    assign Coef_addr     = coef_addr_q;
    assign Data_we       = data_we_q;
    assign Data_clr      = data_clr_q;
    assign Data_addr     = data_addr_q;
    assign Compute_start = compute_q;
    assign Sleep         = sleep_q;

endmodule

// File: tb/tb_msdap_main_ctrl.sv
// ---------------------------------------------------------------------------
// tb_msdap_main_ctrl
// Directed bench for msdap_main_ctrl: init sweep, Rj/coef load, data stream
// with wrap, zero-run sleep and wake, flush, and Start during coefficient load.
// ---------------------------------------------------------------------------
module tb_msdap_main_ctrl;

    logic        Sclk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        Flush_req = 1'b0;
    logic        Word_valid = 1'b0;
    logic [15:0] WordL = '0;
    logic [15:0] WordR = '0;
    logic [2:0]  State;
    logic        InReady;
    logic        Rj_we;
    logic [3:0]  Rj_addr;
    logic        Coef_we;
    logic [8:0]  Coef_addr;
    logic        Data_we;
    logic        Data_clr;
    logic [7:0]  Data_addr;
    logic        Compute_start;
    logic        Sleep;

    int tests = 0;
    int fails = 0;
    int writes;
    int errs;
    int early;
    logic [2:0] saved_state;
    logic       saved_ready;

    msdap_main_ctrl dut (
        .Sclk          (Sclk),
        .Reset         (Reset),
        .Start         (Start),
        .Flush_req     (Flush_req),
        .Word_valid    (Word_valid),
        .WordL         (WordL),
        .WordR         (WordR),
        .State         (State),
        .InReady       (InReady),
        .Rj_we         (Rj_we),
        .Rj_addr       (Rj_addr),
        .Coef_we       (Coef_we),
        .Coef_addr     (Coef_addr),
        .Data_we       (Data_we),
        .Data_clr      (Data_clr),
        .Data_addr     (Data_addr),
        .Compute_start (Compute_start),
        .Sleep         (Sleep)
    );

    always #5 Sclk = ~Sclk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge Sclk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present one pair for exactly one edge; outputs seen afterwards belong to it.
    task automatic apply_stimulus(input logic valid, input logic [15:0] left, input logic [15:0] right);
        Word_valid = valid;
        WordL      = left;
        WordR      = right;
        tick();
        Word_valid = 1'b0;
    endtask

    // Idle n cycles, counting zero-fill writes and their address order.
    task automatic sweep(input int n, output int n_writes, output int n_errs);
        n_writes = 0;
        n_errs   = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (Data_we) begin
                if (!Data_clr || Compute_start || Data_addr != 8'(n_writes)) n_errs++;
                n_writes++;
            end
            if (k == 257) begin
                saved_state = State;
                saved_ready = InReady;
            end
        end
    endtask

    initial begin
        // Reset and init sweep
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_output("reset_state", State, 0);
        check_output("reset_data_we", Data_we, 0);
        check_output("reset_inready", InReady, 0);
        check_output("reset_sleep", Sleep, 0);
        sweep(260, writes, errs);
        check_output("init_clear_count", writes, 256);
        check_output("init_clear_order", errs, 0);
        check_output("init_state_257", saved_state, 1);
        check_output("init_inready_257", saved_ready, 1);

        // Rj load
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 16'(i + 1), 16'(i + 256));
            if (!(Rj_we && Rj_addr == 4'(i) && !Coef_we && !Data_we)) errs++;
            if (i == 14) saved_state = State;
        end
        check_output("rj_sequence", errs, 0);
        check_output("rj_mid_state", saved_state, 2);
        check_output("rj_done_state", State, 3);

        // Coefficient load
        errs = 0;
        for (int i = 0; i < 512; i++) begin
            apply_stimulus(1'b1, 16'(i + 3), 16'(i));
            if (!(Coef_we && Coef_addr == 9'(i) && !Rj_we && !Data_we)) errs++;
        end
        check_output("coef_sequence", errs, 0);
        check_output("coef_done_state", State, 5);

        // 300 nonzero data pairs with an idle cycle after each
        errs   = 0;
        writes = 0;
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(1'b1, 16'(i + 1), 16'(i * 3));
            if (!(Data_we && !Data_clr && Compute_start && Data_addr == 8'(i))) errs++;
            if (Compute_start) writes++;
            tick();
            if (Data_we || Compute_start) errs++;
        end
        check_output("data_sequence", errs, 0);
        check_output("data_compute_count", writes, 300);
        check_output("data_state", State, 6);

        // Zero run into sleep
        errs  = 0;
        early = 0;
        for (int j = 0; j < 800; j++) begin
            apply_stimulus(1'b1, 16'd0, 16'd0);
            if (!(Data_we && Compute_start && Data_addr == 8'(300 + j))) errs++;
            if (j < 799 && Sleep) early++;
        end
        check_output("zero_run_writes", errs, 0);
        check_output("zero_run_early_sleep", early, 0);
        check_output("sleep_rise", Sleep, 1);
        check_output("sleep_state", State, 7);
        errs = 0;
        for (int j = 0; j < 5; j++) begin
            apply_stimulus(1'b1, 16'd0, 16'd0);
            if (Data_we || Compute_start || Data_addr != 8'd75) errs++;
        end
        check_output("sleep_discard", errs, 0);
        apply_stimulus(1'b1, 16'h1234, 16'h0000);
        check_output("wake_data_we", Data_we, 1);
        check_output("wake_compute", Compute_start, 1);
        check_output("wake_addr", Data_addr, 76);
        check_output("wake_state", State, 6);
        check_output("wake_sleep", Sleep, 0);

        // Flush with a simultaneous word
        Flush_req = 1'b1;
        apply_stimulus(1'b1, 16'h5555, 16'h5555);
        check_output("flush_drop_we", Data_we, 0);
        check_output("flush_drop_compute", Compute_start, 0);
        check_output("flush_state", State, 0);
        check_output("flush_inready", InReady, 0);
        sweep(300, writes, errs);
        check_output("flush_clear_count", writes, 256);
        check_output("flush_clear_order", errs, 0);
        check_output("flush_hold_state", State, 5);
        check_output("flush_end_addr", Data_addr, 0);
        apply_stimulus(1'b1, 16'd7, 16'd7);
        check_output("flush_hold_ignore", Data_we, 0);
        check_output("flush_hold_state2", State, 5);
        Flush_req = 1'b0;
        tick();
        apply_stimulus(1'b1, 16'h00AA, 16'h0055);
        check_output("post_flush_we", Data_we, 1);
        check_output("post_flush_addr", Data_addr, 0);
        check_output("post_flush_compute", Compute_start, 1);
        check_output("post_flush_state", State, 6);

        // Start during coefficient load
        Start = 1'b1;
        tick();
        Start = 1'b0;
        sweep(260, writes, errs);
        check_output("start1_state", State, 1);
        for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 16'(i + 9), 16'd1);
        for (int i = 0; i < 200; i++) apply_stimulus(1'b1, 16'(i + 5), 16'd2);
        check_output("coef200_state", State, 4);
        check_output("coef200_addr", Coef_addr, 199);
        Start      = 1'b1;
        Word_valid = 1'b1;
        WordL      = 16'h0BAD;
        tick();
        Start      = 1'b0;
        Word_valid = 1'b0;
        check_output("start_state", State, 0);
        check_output("start_coef_we", Coef_we, 0);
        check_output("start_coef_addr", Coef_addr, 0);
        check_output("start_rj_addr", Rj_addr, 0);
        sweep(260, writes, errs);
        check_output("start_clear_count", writes, 256);
        check_output("start_state_257", saved_state, 1);
        apply_stimulus(1'b1, 16'h0001, 16'h0002);
        check_output("restart_rj_we", Rj_we, 1);
        check_output("restart_rj_addr", Rj_addr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
